// File: rtl/nano_pkg.sv
// Shared nanoprocessor definitions: datapath width and ALU opcode encoding,
// imported by both the controller and the accumulator/ALU stage.
package nano_pkg;

  localparam int WIDTH = 8;

  // Opcodes 13..15 carry no name and decode as NOP.
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_AND = 4'd1,
    OP_OR  = 4'd2,
    OP_XOR = 4'd3,
    OP_ADD = 4'd4,
    OP_ADC = 4'd5,
    OP_SUB = 4'd6,
    OP_SBC = 4'd7,
    OP_ROL = 4'd8,
    OP_ROR = 4'd9,
    OP_LDA = 4'd10,
    OP_CLC = 4'd11,
    OP_SEC = 4'd12
  } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result/cout from op, a (ACC), b (operand), cin (C).
import nano_pkg::*;

module alu_core #(
  parameter int W = nano_pkg::WIDTH
) (
  input  alu_op_t        op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cin,
  output logic [W-1:0]   result,
  output logic           cout
);

  logic [W:0] sum;
  logic [W:0] cin_ext;

  assign cin_ext = {{W{1'b0}}, cin};

  always_comb begin
    sum    = '0;
    result = a;
    cout   = cin;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[W-1:0];
        cout   = sum[W];
      end
      OP_ADC: begin
        sum    = {1'b0, a} + {1'b0, b} + cin_ext;
        result = sum[W-1:0];
        cout   = sum[W];
      end
      // Subtraction wraps in W+1 bits, so the top bit is the borrow out.
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[W-1:0];
        cout   = sum[W];
      end
      OP_SBC: begin
        sum    = {1'b0, a} - {1'b0, b} - cin_ext;
        result = sum[W-1:0];
        cout   = sum[W];
      end
      OP_ROL: begin
        result = {a[W-2:0], cin};
        cout   = a[W-1];
      end
      OP_ROR: begin
        result = {cin, a[W-1:1]};
        cout   = a[0];
      end
      OP_LDA: result = b;
      OP_CLC: cout   = 1'b0;
      OP_SEC: cout   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_alu.sv
// Accumulator/ALU datapath stage: holds ACC, C and the output-port register,
// and returns Z/C to the sequencing controller.
import nano_pkg::*;

module acc_alu #(
  parameter int WIDTH = nano_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       I,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_ACC,
  input  logic             load_OUT,
  output logic [WIDTH-1:0] ACC,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] OUT,
  output logic             Z,
  output logic             C
);

  logic [WIDTH-1:0] result;
  logic             cout;

  alu_core #(.W(WIDTH)) u_core (
    .op     (alu_op_t'(I[3:0])),
    .a      (ACC),
    .b      (data_in),
    .cin    (C),
    .result (result),
    .cout   (cout)
  );

  // OUT samples the pre-edge ACC, so a coincident load_ACC does not leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ACC <= '0;
      C   <= 1'b0;
      OUT <= '0;
    end else begin
      if (load_ACC) begin
        ACC <= result;
        C   <= cout;
      end
      if (load_OUT) OUT <= ACC;
    end
  end

  assign data_out = ACC;
  assign Z        = (ACC == '0);

endmodule

// File: tb/tb_acc_alu.sv
// Directed self-checking bench for acc_alu with hand-computed expectations.
module tb_acc_alu;
  import nano_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] I;
  logic [7:0] data_in;
  logic       load_ACC;
  logic       load_OUT;
  logic [7:0] ACC, data_out, OUT;
  logic       Z, C;

  int checks   = 0;
  int failures = 0;

  acc_alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .I        (I),
    .data_in  (data_in),
    .load_ACC (load_ACC),
    .load_OUT (load_OUT),
    .ACC      (ACC),
    .data_out (data_out),
    .OUT      (OUT),
    .Z        (Z),
    .C        (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one load_ACC strobe across a single rising edge, then settle.
  task automatic do_op(input logic [3:0] op, input logic [7:0] d);
    I        = {4'hA, op};
    data_in  = d;
    load_ACC = 1'b1;
    @(posedge clk);
    #1;
    load_ACC = 1'b0;
    data_in  = 8'hC3;
    #1;
  endtask

  task automatic do_out();
    load_OUT = 1'b1;
    @(posedge clk);
    #1;
    load_OUT = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_op(OP_LDA, 8'h33);
    do_out();
    do_op(OP_LDA, 8'h5A);
    do_op(OP_SEC, 8'h00);
    checks++;
    if (ACC !== 8'h5A || C !== 1'b1 || OUT !== 8'h33) begin
      failures++;
      $display("FAIL pre_reset got ACC=%h C=%b OUT=%h exp 5a 1 33", ACC, C, OUT);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ACC !== 8'h00 || C !== 1'b0 || OUT !== 8'h00 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got ACC=%h C=%b OUT=%h dout=%h exp all 0", ACC, C, OUT, data_out);
    end
    checks++;
    if (Z !== 1'b1) begin
      failures++;
      $display("FAIL reset_z got=%b exp=1", Z);
    end
    // Strobes during reset must be ignored.
    I = {4'h0, OP_SEC}; data_in = 8'h77; load_ACC = 1'b1; load_OUT = 1'b1;
    @(posedge clk);
    #1;
    load_ACC = 1'b0; load_OUT = 1'b0;
    checks++;
    if (ACC !== 8'h00 || C !== 1'b0 || OUT !== 8'h00) begin
      failures++;
      $display("FAIL reset_strobe got ACC=%h C=%b OUT=%h exp all 0", ACC, C, OUT);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_add_chain();
    do_op(OP_LDA, 8'hFF);
    do_op(OP_ADD, 8'h01);
    checks++;
    if (ACC !== 8'h00 || C !== 1'b1 || Z !== 1'b1) begin
      failures++;
      $display("FAIL add_wrap got ACC=%h C=%b Z=%b exp 00 1 1", ACC, C, Z);
    end
    do_op(OP_ADC, 8'h10);
    checks++;
    if (ACC !== 8'h11 || C !== 1'b0 || Z !== 1'b0) begin
      failures++;
      $display("FAIL adc got ACC=%h C=%b Z=%b exp 11 0 0", ACC, C, Z);
    end
    checks++;
    if (data_out !== 8'h11) begin
      failures++;
      $display("FAIL data_out got=%h exp=11", data_out);
    end
  endtask

  task automatic test_sub_borrow();
    do_op(OP_LDA, 8'h05);
    do_op(OP_SUB, 8'h07);
    checks++;
    if (ACC !== 8'hFE || C !== 1'b1) begin
      failures++;
      $display("FAIL sub_borrow got ACC=%h C=%b exp fe 1", ACC, C);
    end
    do_op(OP_SBC, 8'h00);
    checks++;
    if (ACC !== 8'hFD || C !== 1'b0) begin
      failures++;
      $display("FAIL sbc got ACC=%h C=%b exp fd 0", ACC, C);
    end
    do_op(OP_LDA, 8'h00);
    do_op(OP_SUB, 8'h01);
    checks++;
    if (ACC !== 8'hFF || C !== 1'b1) begin
      failures++;
      $display("FAIL sub_zero got ACC=%h C=%b exp ff 1", ACC, C);
    end
  endtask

  task automatic test_rotate();
    do_op(OP_SEC, 8'h00);
    do_op(OP_LDA, 8'h80);
    do_op(OP_ROL, 8'h00);
    checks++;
    if (ACC !== 8'h01 || C !== 1'b1) begin
      failures++;
      $display("FAIL rol got ACC=%h C=%b exp 01 1", ACC, C);
    end
    do_op(OP_ROR, 8'h00);
    checks++;
    if (ACC !== 8'h80 || C !== 1'b1) begin
      failures++;
      $display("FAIL ror got ACC=%h C=%b exp 80 1", ACC, C);
    end
    do_op(OP_CLC, 8'h00);
    do_op(OP_ROR, 8'h00);
    checks++;
    if (ACC !== 8'h40 || C !== 1'b0) begin
      failures++;
      $display("FAIL ror_clc got ACC=%h C=%b exp 40 0", ACC, C);
    end
  endtask

  task automatic test_logic();
    do_op(OP_SEC, 8'h00);
    do_op(OP_LDA, 8'hF0);
    do_op(OP_AND, 8'h3C);
    checks++;
    if (ACC !== 8'h30 || C !== 1'b1) begin
      failures++;
      $display("FAIL and got ACC=%h C=%b exp 30 1", ACC, C);
    end
    do_op(OP_XOR, 8'h30);
    checks++;
    if (ACC !== 8'h00 || Z !== 1'b1 || C !== 1'b1) begin
      failures++;
      $display("FAIL xor got ACC=%h Z=%b C=%b exp 00 1 1", ACC, Z, C);
    end
    do_op(OP_OR, 8'h81);
    checks++;
    if (ACC !== 8'h81 || C !== 1'b1 || Z !== 1'b0) begin
      failures++;
      $display("FAIL or got ACC=%h C=%b Z=%b exp 81 1 0", ACC, C, Z);
    end
  endtask

  task automatic test_collision();
    do_op(OP_LDA, 8'h12);
    I = {4'h0, OP_LDA}; data_in = 8'h34; load_ACC = 1'b1; load_OUT = 1'b1;
    @(posedge clk);
    #1;
    load_ACC = 1'b0; load_OUT = 1'b0;
    checks++;
    if (OUT !== 8'h12 || ACC !== 8'h34) begin
      failures++;
      $display("FAIL collision got OUT=%h ACC=%h exp 12 34", OUT, ACC);
    end
    do_op(OP_SEC, 8'h00);
    do_op(4'd14, 8'hFF);
    checks++;
    if (ACC !== 8'h34 || C !== 1'b1) begin
      failures++;
      $display("FAIL undef_op got ACC=%h C=%b exp 34 1", ACC, C);
    end
    do_op(OP_NOP, 8'hFF);
    checks++;
    if (ACC !== 8'h34 || C !== 1'b1) begin
      failures++;
      $display("FAIL nop got ACC=%h C=%b exp 34 1", ACC, C);
    end
    do_op(OP_CLC, 8'hFF);
    checks++;
    if (ACC !== 8'h34 || C !== 1'b0) begin
      failures++;
      $display("FAIL clc got ACC=%h C=%b exp 34 0", ACC, C);
    end
  endtask

  task automatic test_hold();
    // Several edges with no strobes: nothing moves even as inputs change.
    I = {4'h0, OP_LDA};
    for (int k = 0; k < 3; k++) begin
      data_in = 8'(8'h90 + k);
      @(posedge clk);
    end
    #1;
    checks++;
    if (ACC !== 8'h34 || C !== 1'b0 || OUT !== 8'h12) begin
      failures++;
      $display("FAIL hold got ACC=%h C=%b OUT=%h exp 34 0 12", ACC, C, OUT);
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive strobes each see the freshly committed ACC/C.
    I = {4'h0, OP_LDA}; data_in = 8'hF0; load_ACC = 1'b1;
    @(posedge clk); #1;
    I = {4'h0, OP_ADD}; data_in = 8'h20;
    @(posedge clk); #1;
    I = {4'h0, OP_ADC}; data_in = 8'h01;
    @(posedge clk); #1;
    load_ACC = 1'b0;
    checks++;
    if (ACC !== 8'h12 || C !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back got ACC=%h C=%b exp 12 0", ACC, C);
    end
    do_out();
    checks++;
    if (OUT !== 8'h12) begin
      failures++;
      $display("FAIL out_load got=%h exp=12", OUT);
    end
  endtask

  initial begin
    reset = 1'b1; I = 8'h00; data_in = 8'h00; load_ACC = 1'b0; load_OUT = 1'b0;
    #12;
    reset = 1'b0;
    #1;
    checks++;
    if (ACC !== 8'h00 || C !== 1'b0 || OUT !== 8'h00 || Z !== 1'b1) begin
      failures++;
      $display("FAIL init_reset got ACC=%h C=%b OUT=%h Z=%b exp 00 0 00 1", ACC, C, OUT, Z);
    end
    test_reset();
    test_add_chain();
    test_sub_borrow();
    test_rotate();
    test_logic();
    test_collision();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
